// File: rtl/data_memory_seq.sv
// Data RAM that clears itself and writes preload words after reset; reads are registered (READ_LAT 1..2) with a valid strobe.
// busy=1 during the sequencer and rd/wr are dropped; when ready it accepts one request every cycle and never stalls.
module data_memory_seq #(
  parameter int              DW          = 16,
  parameter int              AW          = 12,
  parameter int              DEPTH       = 4096,
  parameter int              READ_LAT    = 1,
  parameter int              PRELOAD_N   = 4,
  parameter logic [4*DW-1:0] PRELOAD_VAL = {16'h0011, 16'h0040, 16'h0008, 16'h0002}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd,
  input  logic            wr,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wd,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   Rd,
  output logic            rd_valid,
  output logic            busy,
  output logic            err
);

  localparam int NB = DW / 8;
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_CLR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PRE_N    = PW'(PRELOAD_N);
  localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_PRELOAD, S_READY} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            init_we;
  logic [DW-1:0]   init_dat;
  logic [DW-1:0]   ram [DEPTH];

  logic            in_rng;
  logic            rd_acc, wr_acc;
  logic [IW-1:0]   idx;

  logic [DW-1:0]   pd_q [READ_LAT];
  logic            pv_q [READ_LAT];
  logic            pe_q [READ_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    init_we  = 1'b0;
    init_dat = '0;
    case (state_q)
      S_CLEAR: begin
        init_we = 1'b1;
        if (ptr_q == LAST_CLR) begin
          ptr_d   = '0;
          state_d = (PRELOAD_N == 0) ? S_READY : S_PRELOAD;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_PRELOAD: begin
        init_we  = 1'b1;
        init_dat = PRELOAD_VAL[int'(ptr_q[1:0]) * DW +: DW];
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q + 1'b1 == PRE_N) state_d = S_READY;
      end
      S_READY: ;
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy   = (state_q != S_READY);
  assign rd_acc = rd & ~busy;
  assign wr_acc = wr & ~busy;
  // Compared one bit wider so DEPTH == 2**AW never truncates to zero.
  assign in_rng = ({1'b0, addr} < DEPTH_X);
  assign idx    = addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (rst_n && init_we) begin
      ram[ptr_q[IW-1:0]] <= init_dat;
    end else if (rst_n && wr_acc && in_rng) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // The read samples ram before this edge's write lands, so same-address rd+wr returns the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pd_q[i] <= '0;
        pv_q[i] <= 1'b0;
        pe_q[i] <= 1'b0;
      end
    end else begin
      pv_q[0] <= rd_acc;
      pe_q[0] <= (rd_acc | wr_acc) & ~in_rng;
      pd_q[0] <= (rd_acc && in_rng) ? ram[idx] : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        pd_q[i] <= pd_q[i-1];
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  assign rd_valid = pv_q[READ_LAT-1];
  assign err      = pe_q[READ_LAT-1];
  assign Rd       = rd_valid ? pd_q[READ_LAT-1] : '0;

endmodule

// File: tb/tb_data_memory_seq.sv
// Three instances share stimulus: defaults, READ_LAT=2, and DEPTH=1000.
// Expected read and err strobes are queued per instance when a request is driven, then popped when they fall due.
module tb_data_memory_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [11:0] addr = '0;
  logic [15:0] wd = '0;
  logic [1:0]  be = '0;

  logic [15:0] rdat [3];
  logic        vld  [3];
  logic        erro [3];
  logic        bsy  [3];

  always #5 clk = ~clk;

  data_memory_seq u_a (.clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .addr(addr), .wd(wd), .be(be),
                       .Rd(rdat[0]), .rd_valid(vld[0]), .busy(bsy[0]), .err(erro[0]));
  data_memory_seq #(.READ_LAT(2)) u_b (.clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .addr(addr), .wd(wd), .be(be),
                       .Rd(rdat[1]), .rd_valid(vld[1]), .busy(bsy[1]), .err(erro[1]));
  data_memory_seq #(.DEPTH(1000)) u_c (.clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .addr(addr), .wd(wd), .be(be),
                       .Rd(rdat[2]), .rd_valid(vld[2]), .busy(bsy[2]), .err(erro[2]));

  typedef struct {
    int          due;
    logic        v;
    logic [15:0] d;
    logic        e;
  } exp_t;

  exp_t        sbq [3][$];
  logic [15:0] mem [3][4096];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic int dep_of(input int k);
    return (k == 2) ? 1000 : 4096;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  task automatic init_model();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 4096; a++) mem[k][a] = 16'h0000;
      mem[k][0] = 16'h0002;
      mem[k][1] = 16'h0008;
      mem[k][2] = 16'h0040;
      mem[k][3] = 16'h0011;
    end
  endtask

  // One clock step: pop whatever falls due this cycle; otherwise all strobes and Rd must be idle.
  task automatic advance();
    exp_t x;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      x = '{due: 0, v: 1'b0, d: 16'h0000, e: 1'b0};
      if (sbq[k].size() > 0 && sbq[k][0].due == cyc) x = sbq[k].pop_front();
      checks++;
      if (vld[k] !== x.v || rdat[k] !== x.d || erro[k] !== x.e) begin
        failures++;
        $display("FAIL scoreboard dut%0d cyc=%0d got v=%b Rd=%h err=%b expected v=%b Rd=%h err=%b",
                 k, cyc, vld[k], rdat[k], erro[k], x.v, x.d, x.e);
      end
    end
  endtask

  task automatic issue(input logic r, input logic w, input int a, input logic [15:0] d, input logic [1:0] b);
    logic oor;
    rd = r; wr = w; addr = a[11:0]; wd = d; be = b;
    for (int k = 0; k < 3; k++) begin
      oor = (a >= dep_of(k));
      if (r || (w && oor))
        sbq[k].push_back('{due: cyc + lat_of(k), v: r, d: (r && !oor) ? mem[k][a] : 16'h0000, e: oor});
      if (w && !oor)
        for (int l = 0; l < 2; l++) if (b[l]) mem[k][a][8*l +: 8] = d[8*l +: 8];
    end
    advance();
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic drain();
    repeat (4) advance();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sbq[k].size() != 0) begin
        failures++;
        $display("FAIL drain dut%0d pending=%0d expected 0", k, sbq[k].size());
      end
    end
  endtask

  // Releases reset and counts busy cycles; optionally pokes requests mid-sequence, which must be ignored.
  task automatic run_init(input bit poke);
    int nb [3];
    bit any;
    nb = '{0, 0, 0};
    rst_n = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      any = 1'b0;
      for (int k = 0; k < 3; k++) if (bsy[k] === 1'b1) begin nb[k]++; any = 1'b1; end
      if (!any) break;
      if (poke && i >= 200 && i < 210) begin
        rd = 1'b1; wr = 1'b1; addr = i[0] ? 12'd1000 : 12'd5; wd = 16'hFFFF; be = 2'b11;
      end else begin
        rd = 1'b0; wr = 1'b0;
      end
      advance();
    end
    rd = 1'b0; wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (nb[k] != dep_of(k) + 4) begin
        failures++;
        $display("FAIL busy_cycles dut%0d got %0d expected %0d", k, nb[k], dep_of(k) + 4);
      end
    end
    init_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) advance();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bsy[k] !== 1'b1 || vld[k] !== 1'b0 || erro[k] !== 1'b0 || rdat[k] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_state dut%0d got busy=%b v=%b err=%b Rd=%h expected 1 0 0 0000",
                 k, bsy[k], vld[k], erro[k], rdat[k]);
      end
    end
    run_init(1'b1);
  endtask

  task automatic test_preload();
    for (int a = 0; a < 5; a++) issue(1'b1, 1'b0, a, 16'h0, 2'b00);
    issue(1'b1, 1'b0, 5, 16'h0, 2'b00);
    issue(1'b1, 1'b0, 1000, 16'h0, 2'b00);
    drain();
  endtask

  task automatic test_latency();
    issue(1'b0, 1'b1, 7, 16'hA5A5, 2'b11);
    repeat (3) issue(1'b1, 1'b0, 7, 16'h0, 2'b00);
    drain();
  endtask

  task automatic test_byte_en();
    issue(1'b0, 1'b1, 9, 16'h1234, 2'b11);
    issue(1'b0, 1'b1, 9, 16'hABCD, 2'b10);
    issue(1'b1, 1'b0, 9, 16'h0, 2'b00);
    issue(1'b0, 1'b1, 9, 16'h5555, 2'b00);
    issue(1'b1, 1'b0, 9, 16'h0, 2'b00);
    issue(1'b0, 1'b1, 11, 16'h9876, 2'b01);
    issue(1'b1, 1'b0, 11, 16'h0, 2'b00);
    drain();
  endtask

  task automatic test_rw_same();
    issue(1'b1, 1'b1, 3, 16'hFFFF, 2'b11);
    issue(1'b1, 1'b0, 3, 16'h0, 2'b00);
    drain();
  endtask

  task automatic test_out_of_range();
    issue(1'b1, 1'b0, 1000, 16'h0, 2'b00);
    issue(1'b0, 1'b1, 1000, 16'hDEAD, 2'b11);
    issue(1'b1, 1'b0, 0, 16'h0, 2'b00);
    issue(1'b1, 1'b0, 1000, 16'h0, 2'b00);
    issue(1'b1, 1'b1, 4095, 16'hC0DE, 2'b11);
    issue(1'b1, 1'b0, 4095, 16'h0, 2'b00);
    issue(1'b1, 1'b0, 999, 16'h0, 2'b00);
    drain();
  endtask

  task automatic test_back_to_back();
    int a;
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(995, 1010)) : int'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)));
    end
    drain();
  endtask

  task automatic test_mid_reset();
    issue(1'b0, 1'b1, 50, 16'hBEEF, 2'b11);
    issue(1'b1, 1'b0, 50, 16'h0, 2'b00);
    drain();
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    repeat (100) advance();
    rst_n = 1'b0;
    repeat (2) begin
      advance();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (bsy[k] !== 1'b1) begin
          failures++;
          $display("FAIL mid_reset_busy dut%0d got %b expected 1", k, bsy[k]);
        end
      end
    end
    run_init(1'b0);
    issue(1'b1, 1'b0, 50, 16'h0, 2'b00);
    issue(1'b1, 1'b0, 3, 16'h0, 2'b00);
    drain();
  endtask

  initial begin
    init_model();
    test_reset();
    test_preload();
    test_latency();
    test_byte_en();
    test_rw_same();
    test_out_of_range();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
